team_06_pwm_audio_out: RTL and testbench

Audio output back-end. Consumes the 8-bit offset-binary sample and enable level produced by the volume stage and drives a single-bit PWM pin for an external RC filter and speaker. It latches one sample per PWM period and tells upstream when a new sample is wanted. A pop-suppression ramp moves duty between 0 (silent) and 128 (midscale) whenever enable changes.

---
 rtl/team_06_pwm_audio_out.sv | 151 +++++++++++++++
 tb/tb_team_06_pwm_audio_out.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/team_06_pwm_audio_out.sv
// PWM audio back-end: latches one offset-binary sample per 256-tick PWM period
// and ramps duty between 0 and midscale on enable changes to suppress pops.
module team_06_pwm_audio_out #(
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned RAMP_STEP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] audio_in,
    input  logic       en,
    output logic       pwm_out,
    output logic       sample_req,
    output logic       active,
    output logic [7:0] duty
);

    localparam int unsigned       PresW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PresW-1:0]  PresMax = PresW'(CLK_DIV - 1);
    localparam logic [8:0]        Step    = 9'(RAMP_STEP);
    localparam logic [8:0]        Mid     = 9'd128;

    typedef enum logic [1:0] {
        StIdle,
        StRampUp,
        StActive,
        StRampDown
    } state_e;

    state_e           state_q, state_d;
    logic [PresW-1:0] presc_q, presc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             req_q, req_d;
    logic             active_q, active_d;

    logic             tick;
    logic             boundary;
    logic [8:0]       duty_w;
    logic [8:0]       up_sum;
    logic [7:0]       toward_mid;
    logic [7:0]       down_sat;

    // Prescaler and period counter
    always_comb begin
        tick     = (presc_q == PresMax);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
        boundary = tick && (cnt_q == 8'hFF);
    end

    // Saturating ramp arithmetic, done at 9 bits so duty can never wrap
    always_comb begin
        duty_w = {1'b0, duty_q};
        up_sum = duty_w + Step;
        if (duty_w < Mid) begin
            toward_mid = (up_sum >= Mid) ? 8'd128 : up_sum[7:0];
        end else if (duty_w > Mid) begin
            toward_mid = (duty_w >= Mid + Step) ? 8'(duty_w - Step) : 8'd128;
        end else begin
            toward_mid = 8'd128;
        end
        down_sat = (duty_w >= Step) ? 8'(duty_w - Step) : 8'd0;
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        req_d   = 1'b0;
        if (boundary) begin
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        duty_d = toward_mid;
                        // A large step lands on midscale at once; go straight to ACTIVE
                        state_d = (toward_mid == 8'd128) ? StActive : StRampUp;
                    end else begin
                        duty_d = 8'd0;
                    end
                end
                StRampUp: begin
                    if (!en) begin
                        duty_d  = down_sat;
                        state_d = StRampDown;
                    end else begin
                        duty_d = toward_mid;
                        if (toward_mid == 8'd128) begin
                            state_d = StActive;
                        end
                    end
                end
                StActive: begin
                    if (en) begin
                        duty_d = audio_in;
                        req_d  = 1'b1;
                    end else begin
                        duty_d  = down_sat;
                        state_d = StRampDown;
                    end
                end
                StRampDown: begin
                    if (en) begin
                        duty_d  = toward_mid;
                        state_d = StRampUp;
                    end else begin
                        duty_d = down_sat;
                        if (down_sat == 8'd0) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    duty_d  = 8'd0;
                end
            endcase
        end
    end

    // High for the first duty ticks of each period
    always_comb begin
        pwm_d    = (cnt_d < duty_d);
        active_d = (state_d == StActive);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            cnt_q    <= 8'd0;
            duty_q   <= 8'd0;
            pwm_q    <= 1'b0;
            req_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            req_q    <= req_d;
            active_q <= active_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign sample_req = req_q;
    assign active     = active_q;
    assign duty       = duty_q;

endmodule

// File: tb/tb_team_06_pwm_audio_out.sv
// Bench for team_06_pwm_audio_out: per-period vectors on two parameterisations
// plus hand-written reset sequences.
module tb_team_06_pwm_audio_out;

    logic       clk;
    logic       rst;
    logic       en_a, en_b;
    logic [7:0] aud_a, aud_b;
    logic       pwm_a, pwm_b;
    logic       req_a, req_b;
    logic       act_a, act_b;
    logic [7:0] duty_a, duty_b;

    int checks = 0;
    int errors = 0;

    team_06_pwm_audio_out #(
        .CLK_DIV   (1),
        .RAMP_STEP (32)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .audio_in   (aud_a),
        .en         (en_a),
        .pwm_out    (pwm_a),
        .sample_req (req_a),
        .active     (act_a),
        .duty       (duty_a)
    );

    team_06_pwm_audio_out #(
        .CLK_DIV   (4),
        .RAMP_STEP (128)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .audio_in   (aud_b),
        .en         (en_b),
        .pwm_out    (pwm_b),
        .sample_req (req_b),
        .active     (act_b),
        .duty       (duty_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sel;      // 0: dut_a, 1: dut_b
        logic       en;
        logic [7:0] aud;
        logic       glitch;   // toggle en for half of the period, restored before boundary
        logic [7:0] aud_mid;  // audio_in applied halfway through the period
        logic [7:0] exp_duty;
        logic       exp_act;
        logic       exp_req;
    } vec_t;

    vec_t vec_a[$];
    vec_t vec_b[$];

    function automatic vec_t mk(input logic sel, input logic en, input logic [7:0] aud,
                                input logic glitch, input logic [7:0] aud_mid,
                                input logic [7:0] exp_duty, input logic exp_act,
                                input logic exp_req);
        vec_t v;
        v.sel = sel; v.en = en; v.aud = aud; v.glitch = glitch; v.aud_mid = aud_mid;
        v.exp_duty = exp_duty; v.exp_act = exp_act; v.exp_req = exp_req;
        return v;
    endfunction

    function automatic vec_t row(input logic sel, input logic en, input logic [7:0] aud,
                                 input logic [7:0] exp_duty, input logic exp_act,
                                 input logic exp_req);
        return mk(sel, en, aud, 1'b0, aud, exp_duty, exp_act, exp_req);
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Leaves the bench at the negedge just before the first boundary edge
    task automatic align(input int p);
        repeat (p - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Precondition: at the negedge just before a boundary; postcondition: same
    task automatic run_period(input vec_t v, input string tag);
        int   p;
        int   div;
        int   hi;
        int   first_low;
        int   req_cnt;
        int   duty0;
        logic act0;
        logic req0;
        logic s_pwm;
        logic s_req;
        p = v.sel ? 1024 : 256;
        div = v.sel ? 4 : 1;
        hi = 0; first_low = -1; req_cnt = 0; duty0 = 0; act0 = 1'b0; req0 = 1'b0;
        if (v.sel) begin en_b = v.en; aud_b = v.aud; end
        else       begin en_a = v.en; aud_a = v.aud; end
        for (int i = 0; i < p; i++) begin
            @(posedge clk);
            @(negedge clk);
            s_pwm = v.sel ? pwm_b : pwm_a;
            s_req = v.sel ? req_b : req_a;
            if (i == 0) begin
                duty0 = v.sel ? int'(duty_b) : int'(duty_a);
                act0  = v.sel ? act_b : act_a;
                req0  = s_req;
            end
            if (s_pwm) hi++;
            else if (first_low < 0) first_low = i;
            if (s_req) req_cnt++;
            if (v.glitch && (i == p / 4 || i == 3 * p / 4)) begin
                if (v.sel) en_b = (i == p / 4) ? ~v.en : v.en;
                else       en_a = (i == p / 4) ? ~v.en : v.en;
            end
            if (i == p / 2) begin
                if (v.sel) aud_b = v.aud_mid;
                else       aud_a = v.aud_mid;
            end
        end
        if (first_low < 0) first_low = p;
        check({tag, "_duty"}, duty0, int'(v.exp_duty));
        check({tag, "_active"}, int'(act0), int'(v.exp_act));
        check({tag, "_pwm_high"}, hi, int'(v.exp_duty) * div);
        check({tag, "_pwm_first_low"}, first_low, int'(v.exp_duty) * div);
        check({tag, "_req_count"}, req_cnt, int'(v.exp_req));
        check({tag, "_req_first"}, int'(req0), int'(v.exp_req));
    endtask

    initial begin
        // Ramp up from IDLE, play samples, glitch, ramp down and back up
        vec_a.push_back(row(0, 0, 128,   0, 0, 0));
        vec_a.push_back(row(0, 1, 128,  32, 0, 0));
        vec_a.push_back(row(0, 1, 128,  64, 0, 0));
        vec_a.push_back(row(0, 1, 128,  96, 0, 0));
        vec_a.push_back(row(0, 1, 128, 128, 1, 0));
        vec_a.push_back(row(0, 1, 192, 192, 1, 1));
        vec_a.push_back(mk (0, 1, 192, 0, 250, 192, 1, 1));
        vec_a.push_back(row(0, 1, 250, 250, 1, 1));
        vec_a.push_back(row(0, 1,   0,   0, 1, 1));
        vec_a.push_back(row(0, 1, 255, 255, 1, 1));
        vec_a.push_back(mk (0, 1, 200, 1, 200, 200, 1, 1));
        vec_a.push_back(row(0, 1, 200, 200, 1, 1));
        vec_a.push_back(row(0, 0, 200, 168, 0, 0));
        vec_a.push_back(row(0, 0, 200, 136, 0, 0));
        vec_a.push_back(row(0, 0, 200, 104, 0, 0));
        vec_a.push_back(row(0, 0, 200,  72, 0, 0));
        vec_a.push_back(row(0, 1, 200, 104, 0, 0));
        vec_a.push_back(row(0, 1, 200, 128, 1, 0));
        vec_a.push_back(row(0, 1, 200, 200, 1, 1));
        vec_a.push_back(row(0, 0, 200, 168, 0, 0));
        vec_a.push_back(row(0, 0, 200, 136, 0, 0));
        vec_a.push_back(row(0, 0, 200, 104, 0, 0));
        vec_a.push_back(row(0, 0, 200,  72, 0, 0));
        vec_a.push_back(row(0, 0, 200,  40, 0, 0));
        vec_a.push_back(row(0, 0, 200,   8, 0, 0));
        vec_a.push_back(row(0, 0, 200,   0, 0, 0));
        vec_a.push_back(row(0, 0, 200,   0, 0, 0));
        vec_a.push_back(row(0, 1, 200,  32, 0, 0));
        vec_a.push_back(row(0, 1, 200,  64, 0, 0));
        vec_a.push_back(row(0, 1, 200,  96, 0, 0));
        vec_a.push_back(row(0, 1, 200, 128, 1, 0));
        vec_a.push_back(row(0, 1, 200, 200, 1, 1));

        // CLK_DIV=4, RAMP_STEP=128: one-boundary ramp, 1024-cycle period
        vec_b.push_back(row(1, 0,  64,   0, 0, 0));
        vec_b.push_back(row(1, 1,  64, 128, 1, 0));
        vec_b.push_back(row(1, 1,  64,  64, 1, 1));
        vec_b.push_back(row(1, 1,  64,  64, 1, 1));
        vec_b.push_back(row(1, 0,  64,   0, 0, 0));

        en_a = 1'b0; en_b = 1'b0; aud_a = 8'd128; aud_b = 8'd128;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_pwm", int'(pwm_a), 0);
        check("reset_duty", int'(duty_a), 0);
        check("reset_active", int'(act_a), 0);
        check("reset_req", int'(req_a), 0);
        rst = 1'b0;
        align(256);
        foreach (vec_a[k]) run_period(vec_a[k], $sformatf("a%0d", k));

        // Asynchronous reset just after a boundary latched duty 200 in ACTIVE
        en_a = 1'b1; aud_a = 8'd200;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_pwm", int'(pwm_a), 1);
        check("pre_rst_duty", int'(duty_a), 200);
        check("pre_rst_active", int'(act_a), 1);
        check("pre_rst_req", int'(req_a), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pwm", int'(pwm_a), 0);
        check("async_rst_duty", int'(duty_a), 0);
        check("async_rst_active", int'(act_a), 0);
        check("async_rst_req", int'(req_a), 0);
        en_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        align(256);
        run_period(row(0, 0, 200, 0, 0, 0), "post_rst_idle");
        run_period(row(0, 1, 200, 32, 0, 0), "post_rst_ramp");

        en_a = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        align(1024);
        foreach (vec_b[k]) run_period(vec_b[k], $sformatf("b%0d", k));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
